regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant with starvation override,
// one-cycle registered write stage and one-hot write-enable decode ($0 dropped).
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [31:0]               wr_en,
    output logic [4:0]                wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [1:0]                wr_src,
    output logic                      starve_hit
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [1:0]        rr_ptr_q;
    logic [CW-1:0]     wait_cnt_q [NUM_REQ];
    logic [31:0]       wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [1:0]        wr_src_q;
    logic              starve_hit_q;

    logic [NUM_REQ-1:0] grant_vec;
    logic [1:0]         grant_idx;
    logic               grant_any;
    logic               grant_ovr;
    logic [1:0]         scan_idx;
    logic [4:0]         sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Override pass first (lowest starving index), then round-robin scan from rr_ptr.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        grant_ovr = 1'b0;
        scan_idx  = '0;
        if (!wb_stall) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && req_valid[i] && wait_cnt_q[i] == CW'(MAX_WAIT)) begin
                    grant_any = 1'b1;
                    grant_ovr = 1'b1;
                    grant_idx = 2'(i);
                end
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx = 2'((32'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
            if (grant_any) grant_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = req_addr[5*grant_idx +: 5];
        sel_data = req_data[DATA_W*grant_idx +: DATA_W];
        wr_en_d  = (sel_addr != 5'd0) ? (32'd1 << sel_addr) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_src_q     <= '0;
            starve_hit_q <= 1'b0;
        end else begin
            if (grant_any)
                rr_ptr_q <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_vec[i] || !req_valid[i])
                    wait_cnt_q[i] <= '0;
                else if (wait_cnt_q[i] != CW'(MAX_WAIT))
                    wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
            end
            if (grant_any) begin
                wr_en_q      <= wr_en_d;
                wr_addr_q    <= sel_addr;
                wr_data_q    <= sel_data;
                wr_src_q     <= grant_idx;
                starve_hit_q <= grant_ovr;
            end else begin
                wr_en_q      <= '0;
                starve_hit_q <= 1'b0;
            end
        end
    end

    assign req_ready  = grant_vec;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_src     = wr_src_q;
    assign starve_hit = starve_hit_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for steady-state grants,
// hand sequences for stall/starvation, round-robin wrap and async reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_stall = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic [31:0] wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_src;
    logic        starve_hit;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .MAX_WAIT(7)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_src(wr_src), .starve_hit(starve_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic        stall;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic [31:0] en;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  src;
        logic        sh;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_ad(input logic [4:0] a0, a1, a2, input logic [31:0] d0, d1, d2);
        req_addr = {a2, a1, a0};
        req_data = {d2, d1, d0};
    endtask

    task automatic chk_out(input string nm, input logic [31:0] en, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [1:0] src, input logic sh);
        chk({nm, ".wr_en"}, wr_en, en);
        chk({nm, ".wr_addr"}, 32'(wr_addr), 32'(wa));
        chk({nm, ".wr_data"}, wr_data, wd);
        chk({nm, ".wr_src"}, 32'(wr_src), 32'(src));
        chk({nm, ".starve_hit"}, 32'(starve_hit), 32'(sh));
    endtask

    // Entered and left at posedge+1: apply inputs, check grant, clock, check registered write.
    task automatic step(input string nm, input logic [2:0] v, input logic st, input logic [2:0] rdy,
                        input logic [31:0] en, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] src, input logic sh);
        req_valid = v;
        wb_stall  = st;
        #1;
        chk({nm, ".req_ready"}, 32'(req_ready), 32'(rdy));
        @(posedge clk);
        #1;
        chk_out(nm, en, wa, wd, src, sh);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        req_valid = '0;
        wb_stall  = 1'b0;
        rst_n     = 1'b0;
        #1;
        if (check) chk_out("reset", 32'h0, 5'd0, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'b001, 1'b0, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                   3'b001, 32'h0000_0020, 5'd5, 32'hDEADBEEF, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0,
                   3'b001, 32'h0, 5'd0, 32'h12345678, 2'd0, 1'b0};
        tbl[2] = '{1'b1, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b001, 32'h2, 5'd1, 32'hA0, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b010, 32'h4, 5'd2, 32'hA1, 2'd1, 1'b0};
        tbl[4] = '{1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b100, 32'h8, 5'd3, 32'hA2, 2'd2, 1'b0};
        tbl[5] = '{1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b001, 32'h2, 5'd1, 32'hA0, 2'd0, 1'b0};
        tbl[6] = '{1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b010, 32'h4, 5'd2, 32'hA1, 2'd1, 1'b0};
        tbl[7] = '{1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b100, 32'h8, 5'd3, 32'hA2, 2'd2, 1'b0};
        tbl[8] = '{1'b0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                   3'b000, 32'h0, 5'd3, 32'hA2, 2'd2, 1'b0};

        do_reset(1'b1);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst) do_reset(1'b0);
            set_ad(tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            step($sformatf("vec%0d", i), tbl[i].valid, tbl[i].stall, tbl[i].rdy,
                 tbl[i].en, tbl[i].waddr, tbl[i].wdata, tbl[i].src, tbl[i].sh);
        end

        // Stall while req1 waits; its counter saturates, so it wins by override on release.
        do_reset(1'b0);
        set_ad(5'd10, 5'd11, 5'd12, 32'hB0, 32'hB1, 32'hB2);
        for (int i = 0; i < 10; i++)
            step("stall", 3'b010, 1'b1, 3'b000, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0);
        step("ovr1", 3'b111, 1'b0, 3'b010, 32'h0000_0800, 5'd11, 32'hB1, 2'd1, 1'b1);
        step("rr2",  3'b111, 1'b0, 3'b100, 32'h0000_1000, 5'd12, 32'hB2, 2'd2, 1'b0);
        step("rr0",  3'b111, 1'b0, 3'b001, 32'h0000_0400, 5'd10, 32'hB0, 2'd0, 1'b0);

        // Round-robin skip: last grant to 2, then 0 and 2 compete.
        step("last2", 3'b100, 1'b0, 3'b100, 32'h0000_1000, 5'd12, 32'hB2, 2'd2, 1'b0);
        step("wrap0", 3'b101, 1'b0, 3'b001, 32'h0000_0400, 5'd10, 32'hB0, 2'd0, 1'b0);
        step("then2", 3'b101, 1'b0, 3'b100, 32'h0000_1000, 5'd12, 32'hB2, 2'd2, 1'b0);

        // Grant to 1 leaves rr_ptr=2; stall must not disturb the registered write.
        step("pre1", 3'b010, 1'b0, 3'b010, 32'h0000_0800, 5'd11, 32'hB1, 2'd1, 1'b0);
        wb_stall = 1'b1;
        #1;
        chk("stall_hold.req_ready", 32'(req_ready), 32'h0);
        chk("stall_hold.wr_en", wr_en, 32'h0000_0800);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 32'h0, 5'd0, 32'h0, 2'd0, 1'b0);
        rst_n    = 1'b1;
        wb_stall = 1'b0;
        step("post_rst", 3'b110, 1'b0, 3'b010, 32'h0000_0800, 5'd11, 32'hB1, 2'd1, 1'b0);

        // All three starve together: served lowest index first, each flagged.
        do_reset(1'b0);
        for (int i = 0; i < 8; i++)
            step("stall3", 3'b111, 1'b1, 3'b000, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0);
        step("starve0", 3'b111, 1'b0, 3'b001, 32'h0000_0400, 5'd10, 32'hB0, 2'd0, 1'b1);
        step("starve1", 3'b111, 1'b0, 3'b010, 32'h0000_0800, 5'd11, 32'hB1, 2'd1, 1'b1);
        step("starve2", 3'b111, 1'b0, 3'b100, 32'h0000_1000, 5'd12, 32'hB2, 2'd2, 1'b1);
        step("norm0",   3'b111, 1'b0, 3'b001, 32'h0000_0400, 5'd10, 32'hB0, 2'd0, 1'b0);
        step("idle",    3'b000, 1'b0, 3'b000, 32'h0, 5'd10, 32'hB0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
